regfile_operand_reader: RTL and testbench
=========================================

// Module: regfile_operand_reader
// PURPOSE
//  Read-side front end of the register file. Accepts issue requests (rs1/rs2/rd) with a
//  valid/ready handshake and drives the regfile read-address ports. Forwards writeback
//  data when the regfile floats a read that collides with a write in the same cycle.
//  Keeps a pending-write scoreboard and stalls RAW/WAW hazards.
//  Delivers registered operand pairs to the execute stage, one cycle after acceptance.
// PARAMETERS
//  DATA_WIDTH   32  operand/writeback data width
//  ADDR_WIDTH   5   register index width (2**ADDR_WIDTH registers, reg 0 hard-wired 0)
//  MAX_PENDING  4   max outstanding writes in flight (1..2**ADDR_WIDTH-1)
// PORTS
//  clock            in   1    rising-edge clock
//  ctrl_reset_n     in   1    asynchronous reset, active low
//  in_valid         in   1    issue request valid
//  in_ready         out  1    request accepted when in_valid & in_ready at clock edge
//  in_rs1/in_rs2    in   AW   source register indices
//  in_rd            in   AW   destination register index
//  in_rd_we         in   1    request will write in_rd later
//  rf_readRegA/B    out  AW   to regfile read-address ports (combinational = in_rs1/in_rs2)
//  rf_dataA/B       in   DW   from regfile; may be high-Z on read/write collision
//  wb_valid         in   1    writeback this cycle (same signal as regfile write enable)
//  wb_reg           in   AW   writeback index
//  wb_data          in   DW   writeback data
//  out_valid        out  1    operand pair valid
//  out_ready        in   1    consumer accepts when out_valid & out_ready
//  out_a/out_b      out  DW   operands for rs1/rs2
//  out_rd/out_rd_we out  AW/1 destination info, registered with operands
//  err_wb_unexp     out  1    sticky: writeback to a register not marked busy
// BEHAVIOUR
//  Reset (async, ctrl_reset_n=0): out_valid=0, out_a/out_b/out_rd=0, out_rd_we=0,
//   busy[*]=0, pending count=0, err_wb_unexp=0. Reset mid-transfer drops the held output.
//  wb_hit(r) = wb_valid & wb_reg==r & r!=0.
//  hazard = (rs1!=0 & busy[rs1] & !wb_hit(rs1)) | (rs2!=0 & busy[rs2] & !wb_hit(rs2))
//   | (in_rd_we & rd!=0 & busy[rd] & !wb_hit(rd))
//   | (in_rd_we & rd!=0 & count==MAX_PENDING & !(wb_valid & wb_reg!=0 & busy[wb_reg])).
//  in_ready = !hazard & (!out_valid | out_ready); combinational, no dependence on in_valid.
//  Operand select per source: idx==0 -> 0; wb_hit(idx) -> wb_data; else rf_data.
//   Never propagate Z/X from the regfile.
//  Accept: out_a/out_b/out_rd/out_rd_we load at the edge; out_valid=1 next cycle (latency 1).
//  Output hold: out_valid & !out_ready -> all out_* stable; pop without accept -> out_valid=0.
//  Pop and accept in the same cycle: back-to-back, full throughput.
//  Scoreboard per edge: clear busy[wb_reg] on wb_valid (wb_reg!=0); then set busy[rd] on an
//   accept with in_rd_we & rd!=0; a set wins over a clear of the same register.
//  count = popcount(busy), updated incrementally with +1/-1/0.
//   Simultaneous set and clear leaves the count unchanged. Count never exceeds MAX_PENDING.
//  wb_valid with wb_reg!=0 and busy[wb_reg]=0: set err_wb_unexp (sticky until reset).
//   busy and count are unchanged.
//  wb_reg==0: ignored entirely.
// TESTING
//  1 Reset, rf holds r5=0x11, issue rs1=5 rs2=0 -> next cycle out_valid, out_a=0x11, out_b=0.
//  2 Issue rd=7 we; then rs1=7 -> in_ready=0 until wb_valid,wb_reg=7,wb_data=0xCAFE.
//    In that cycle (rf_dataA=Z) accept; out_a=0xCAFE.
//  3 MAX_PENDING=4: four writes rd=1..4 accepted, 5th (rd=9) stalls.
//    Accepted in the cycle wb_reg=2 retires; count stays 4.
//  4 out_ready=0 for 3 cycles with in_valid held: out_* stable, in_ready=0.
//    Then out_ready=1 -> consecutive accepts, one result per cycle.
//  5 wb_valid, wb_reg=12 never issued -> err_wb_unexp=1, busy unchanged.
//    Assert ctrl_reset_n=0 mid-stall -> all outputs 0 asynchronously.
//  6 Same-cycle wb_reg=3 and accept rd=3 we -> busy[3]=1 afterwards, count unchanged.

Source files
------------

// File: rtl/regfile_operand_reader.sv
// regfile_operand_reader: issue-side operand fetch with writeback forwarding,
// pending-write scoreboard and a one-deep registered output stage.
module regfile_operand_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_we,
  output logic [ADDR_WIDTH-1:0] rf_readRegA,
  output logic [ADDR_WIDTH-1:0] rf_readRegB,
  input  logic [DATA_WIDTH-1:0] rf_dataA,
  input  logic [DATA_WIDTH-1:0] rf_dataB,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_we,
  output logic                  err_wb_unexp
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int CW   = $clog2(MAX_PENDING + 1);
  logic [NREG-1:0]       busy, busy_nx;
  logic [CW-1:0]         count;
  logic                  wb_any, hit1, hit2, hitd, retire, full, hazard, accept, set_rd;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  assign rf_readRegA = in_rs1;
  assign rf_readRegB = in_rs2;
  always_comb begin
    wb_any   = wb_valid & (wb_reg != '0);
    hit1     = wb_any & (wb_reg == in_rs1);
    hit2     = wb_any & (wb_reg == in_rs2);
    hitd     = wb_any & (wb_reg == in_rd);
    retire   = wb_any & busy[wb_reg];
    full     = count == CW'(MAX_PENDING);
    hazard   = ((in_rs1 != '0) & busy[in_rs1] & !hit1)
             | ((in_rs2 != '0) & busy[in_rs2] & !hit2)
             | (in_rd_we & (in_rd != '0) & busy[in_rd] & !hitd)
             | (in_rd_we & (in_rd != '0) & full & !retire);
    in_ready = !hazard & (!out_valid | out_ready);
    accept   = in_valid & in_ready;
    set_rd   = accept & in_rd_we & (in_rd != '0);
    // a colliding read floats the regfile bus, so forwarding must win over rf_data
    op_a     = (in_rs1 == '0) ? '0 : hit1 ? wb_data : rf_dataA;
    op_b     = (in_rs2 == '0) ? '0 : hit2 ? wb_data : rf_dataB;
    busy_nx  = busy;
    if (wb_any) busy_nx[wb_reg] = 1'b0;
    if (set_rd) busy_nx[in_rd] = 1'b1;
  end
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      busy         <= '0;
      count        <= '0;
      err_wb_unexp <= 1'b0;
    end else begin
      out_valid <= accept | (out_valid & !out_ready);
      if (accept) begin
        out_a     <= op_a;
        out_b     <= op_b;
        out_rd    <= in_rd;
        out_rd_we <= in_rd_we;
      end
      busy  <= busy_nx;
      count <= count + CW'(set_rd) - CW'(retire);
      if (wb_any & !busy[wb_reg]) err_wb_unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_operand_reader.sv
// tb_regfile_operand_reader: directed issue sequences with a queue scoreboard
// checked by an independent output monitor, plus direct handshake/flag checks.
module tb_regfile_operand_reader;
  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        in_valid, in_ready, in_rd_we;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_readRegA, rf_readRegB, wb_reg, out_rd;
  logic [31:0] rf_dataA, rf_dataB, wb_data, out_a, out_b;
  logic        wb_valid, out_valid, out_ready, out_rd_we, err_wb_unexp;
  logic [31:0] rf [32];
  logic [69:0] q [$];
  logic [69:0] got, want;
  int          n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  regfile_operand_reader dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_readRegA(rf_readRegA), .rf_readRegB(rf_readRegB),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .err_wb_unexp(err_wb_unexp)
  );

  // regfile model: a read colliding with the same-cycle write floats the bus
  assign rf_dataA = (wb_valid && wb_reg != 0 && wb_reg == rf_readRegA) ? 'z : rf[rf_readRegA];
  assign rf_dataB = (wb_valid && wb_reg != 0 && wb_reg == rf_readRegB) ? 'z : rf[rf_readRegB];
  always @(posedge clock) if (wb_valid && wb_reg != 0) rf[wb_reg] <= wb_data;

  always @(negedge clock) begin
    if (ctrl_reset_n && out_valid && out_ready) begin
      got = {out_a, out_b, out_rd, out_rd_we};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got a=%h b=%h rd=%0d we=%0b, want no output", out_a, out_b, out_rd, out_rd_we);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL sb_operands: got a=%h b=%h rd=%0d we=%0b, want a=%h b=%h rd=%0d we=%0b",
                   out_a, out_b, out_rd, out_rd_we, want[69:38], want[37:6], want[5:1], want[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic we);
    q.push_back({a, b, rd, we});
  endtask

  task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v; wb_reg = r; wb_data = d;
  endtask

  task automatic ready_is(input string name, input logic exp);
    #1;
    check(name, {31'd0, in_ready}, {31'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h0;
    rf[5] = 32'h11;
    ctrl_reset_n = 1'b0; out_ready = 1'b1;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
    wb(0, 0, 0);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_rd_we", {31'd0, out_rd_we}, 0);
    check("rst_err", {31'd0, err_wb_unexp}, 0);
    repeat (2) @(posedge clock);
    #1 ctrl_reset_n = 1'b1;

    // basic read, latency 1
    req(5, 0, 0, 0); ready_is("t1_ready", 1); push(32'h11, 0, 0, 0); tick();
    in_valid = 0;
    check("t1_latency", {31'd0, out_valid}, 1);

    // RAW stall resolved by a forwarded writeback
    req(0, 0, 7, 1); ready_is("t2_wr_ready", 1); push(0, 0, 7, 1); tick();
    req(7, 0, 0, 0);
    ready_is("t2_stall0", 0); tick();
    ready_is("t2_stall1", 0);
    wb(1, 7, 32'hCAFE);
    ready_is("t2_fwd_ready", 1); push(32'hCAFE, 0, 0, 0); tick();
    wb(0, 0, 0); in_valid = 0;

    // pending limit
    for (int i = 1; i <= 4; i++) begin
      req(0, 0, 5'(i), 1); ready_is("t3_fill", 1); push(0, 0, 5'(i), 1); tick();
    end
    req(0, 0, 9, 1); ready_is("t3_full0", 0); tick();
    ready_is("t3_full1", 0);
    wb(1, 2, 32'h2222);
    ready_is("t3_retire_ready", 1); push(0, 0, 9, 1); tick();
    wb(0, 0, 0);
    req(0, 0, 10, 1); ready_is("t3_still_full", 0);
    req(2, 0, 0, 0); ready_is("t3_r2_free", 1); push(32'h2222, 0, 0, 0); tick();
    in_valid = 0;
    wb(1, 1, 32'hA1); tick();
    wb(1, 4, 32'hA4); tick();
    wb(1, 9, 32'hA9); tick();
    wb(0, 0, 0);
    check("t3_err_clean", {31'd0, err_wb_unexp}, 0);

    // output back-pressure, then full throughput
    req(6, 8, 0, 0); ready_is("t4_a_ready", 1); push(32'h1006, 32'h1008, 0, 0); tick();
    out_ready = 1'b0;
    req(10, 11, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ready_is("t4_hold_ready", 0);
      check("t4_hold_valid", {31'd0, out_valid}, 1);
      check("t4_hold_a", out_a, 32'h1006);
      check("t4_hold_b", out_b, 32'h1008);
      tick();
    end
    out_ready = 1'b1;
    ready_is("t4_release_ready", 1); push(32'h100A, 32'h100B, 0, 0); tick();
    check("t4_b2b_a", out_a, 32'h100A);
    req(12, 13, 0, 0); ready_is("t4_b2b_ready1", 1); push(32'h100C, 32'h100D, 0, 0); tick();
    req(14, 15, 0, 0); ready_is("t4_b2b_ready2", 1); push(32'h100E, 32'h100F, 0, 0); tick();
    check("t4_b2b_valid", {31'd0, out_valid}, 1);
    in_valid = 0;

    // unexpected writeback, then async reset mid-stall
    wb(1, 12, 32'h5555); tick();
    wb(0, 0, 0);
    check("t5_err_set", {31'd0, err_wb_unexp}, 1);
    req(12, 0, 0, 0); ready_is("t5_r12_not_busy", 1); push(32'h5555, 0, 0, 0); tick();
    req(3, 0, 0, 0); ready_is("t5_r3_still_busy", 0);
    in_valid = 0;
    tick();
    check("t5_err_sticky", {31'd0, err_wb_unexp}, 1);
    out_ready = 1'b0;
    req(1, 6, 13, 1); tick();
    req(3, 0, 0, 0);
    #1 check("t5_held_valid", {31'd0, out_valid}, 1);
    #1 ctrl_reset_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 0);
    check("t5_rst_a", out_a, 0);
    check("t5_rst_b", out_b, 0);
    check("t5_rst_rd", {27'd0, out_rd}, 0);
    check("t5_rst_rd_we", {31'd0, out_rd_we}, 0);
    check("t5_rst_err", {31'd0, err_wb_unexp}, 0);
    in_valid = 0; out_ready = 1'b1;
    @(posedge clock);
    #1 ctrl_reset_n = 1'b1;

    // same-cycle retire and re-claim of r3 with the scoreboard full
    req(0, 0, 3, 1); ready_is("t6_fill3", 1); push(0, 0, 3, 1); tick();
    req(0, 0, 1, 1); ready_is("t6_fill1", 1); push(0, 0, 1, 1); tick();
    req(0, 0, 2, 1); ready_is("t6_fill2", 1); push(0, 0, 2, 1); tick();
    req(0, 0, 4, 1); ready_is("t6_fill4", 1); push(0, 0, 4, 1); tick();
    req(0, 0, 3, 1); wb(1, 3, 32'h3333);
    ready_is("t6_swap_ready", 1); push(0, 0, 3, 1); tick();
    wb(0, 0, 0);
    req(3, 0, 0, 0); ready_is("t6_r3_busy", 0);
    req(0, 0, 5, 1); ready_is("t6_count_full", 0);
    in_valid = 0;
    check("t6_err_clean", {31'd0, err_wb_unexp}, 0);

    repeat (3) tick();
    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
